// File: rtl/grn_floyd_ctrl.sv
// grn_floyd_ctrl: sweeps a range of initial states and runs Floyd cycle detection
// on an attached pair of next-state registers, one result per trajectory.
`default_nettype none

module grn_floyd_ctrl #(
  parameter int STATE_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STATE_W-1:0] init_first,
  input  logic [STATE_W-1:0] init_last,
  input  logic [CNT_W-1:0]   max_steps,
  output logic               reset_nos,
  output logic [STATE_W-1:0] init_state,
  output logic               start_s0,
  output logic               start_s1,
  input  logic [STATE_W-1:0] sos_s0,
  input  logic [STATE_W-1:0] sos_s1,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [STATE_W-1:0] res_init,
  output logic [CNT_W-1:0]   res_steps,
  output logic               res_timeout,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_REPORT = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  state_t             state_q;
  logic [STATE_W-1:0] cur_q;
  logic [STATE_W-1:0] last_q;
  logic [CNT_W-1:0]   max_q;
  logic [CNT_W-1:0]   c_q;
  logic               reset_nos_q;
  logic               adv_q;
  logic               res_valid_q;
  logic [STATE_W-1:0] res_init_q;
  logic [CNT_W-1:0]   res_steps_q;
  logic               res_timeout_q;
  logic               busy_q;
  logic               done_q;

  logic               meet_w;
  assign meet_w = (c_q != '0) && !c_q[0] && (sos_s0 == sos_s1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cur_q         <= '0;
      last_q        <= '0;
      max_q         <= '0;
      c_q           <= '0;
      reset_nos_q   <= 1'b0;
      adv_q         <= 1'b0;
      res_valid_q   <= 1'b0;
      res_init_q    <= '0;
      res_steps_q   <= '0;
      res_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      reset_nos_q <= 1'b0;
      adv_q       <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cur_q       <= init_first;
            last_q      <= init_last;
            max_q       <= max_steps;
            c_q         <= '0;
            reset_nos_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_LOAD;
          end
        end
        S_LOAD: begin
          c_q     <= '0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          // Outputs are registered, so the cycle carrying an advance pulse is
          // skipped: the state registers only show the new values one cycle later.
          if (!adv_q) begin
            if (meet_w || (c_q == max_q)) begin
              res_valid_q   <= 1'b1;
              res_init_q    <= cur_q;
              res_steps_q   <= c_q;
              res_timeout_q <= !meet_w;
              state_q       <= S_REPORT;
            end else begin
              adv_q <= 1'b1;
              c_q   <= c_q + 1'b1;
            end
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            if (cur_q == last_q) begin
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              cur_q       <= cur_q + 1'b1;
              reset_nos_q <= 1'b1;
              state_q     <= S_LOAD;
            end
          end
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign reset_nos   = reset_nos_q;
  assign init_state  = cur_q;
  assign start_s0    = adv_q;
  assign start_s1    = adv_q;
  assign res_valid   = res_valid_q;
  assign res_init    = res_init_q;
  assign res_steps   = res_steps_q;
  assign res_timeout = res_timeout_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

`default_nettype wire
